// File: rtl/nx_pipe_pkg.sv
// Shared defaults and stage-index names for the nx pipeline controller.
package nx_pipe_pkg;

    localparam int NSTAGE_DEF = 5;
    localparam int CNT_W_DEF  = 32;
    localparam int SIDX_W_DEF = 3;

    // Classic five-stage names; deeper pipes simply use raw indices.
    localparam int IF  = 0;
    localparam int ID  = 1;
    localparam int EXE = 2;
    localparam int MEM = 3;
    localparam int WB  = 4;

endpackage

// File: rtl/nx_sat_cnt.sv
// Saturating up-counter with synchronous clear that beats increment.
module nx_sat_cnt
    import nx_pipe_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up, stick at all-ones, clear on request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/nx_pipe_ctrl.sv
// Valid/allowin handshake controller for an in-order NSTAGE pipeline,
// with redirect flush and retire/stall statistics.
module nx_pipe_ctrl
    import nx_pipe_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SIDX_W = SIDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [NSTAGE-1:0] ready_go,
    input  logic              flush_req,
    input  logic [SIDX_W-1:0] flush_stage,
    input  logic              cnt_clr,
    output logic [NSTAGE-1:0] stage_valid,
    output logic [NSTAGE-1:0] stage_allowin,
    output logic [NSTAGE-1:0] stage_load,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [NSTAGE-1:0] valid;
    logic [NSTAGE-1:0] valid_nxt;
    logic [NSTAGE-1:0] allowin;
    logic [NSTAGE-1:0] done;
    logic [NSTAGE-1:0] feed;
    logic              flush_hit;
    int                fidx;

    // A stage is done when it holds an instruction that finished its work.
    assign done = valid & ready_go;
    // What each stage would receive: the fetch for IF, the upstream result otherwise.
    assign feed = {done[NSTAGE-2:0], fetch_valid};

    assign fidx      = int'(flush_stage);
    assign flush_hit = flush_req && (fidx < NSTAGE);

    // Backpressure chain from WB down to IF; the last stage always drains.
    always_comb begin : allowin_chain
        logic down;
        down = 1'b1;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            down       = ~valid[i] | (ready_go[i] & down);
            allowin[i] = down;
        end
    end

    // Next valids: shift on allowin, hold otherwise; a flush kills the stages
    // younger than the redirector and treats the redirector's input as a bubble,
    // so the redirecting instruction stays put while it is still busy.
    always_comb begin
        valid_nxt = valid;
        for (int i = 0; i < NSTAGE; i++) begin
            valid_nxt[i] = allowin[i] ? feed[i] : valid[i];
            if (flush_hit) begin
                if (i < fidx)
                    valid_nxt[i] = 1'b0;
                else if (i == fidx)
                    valid_nxt[i] = valid[i] & ~allowin[i];
            end
        end
    end

    // Stage valid register; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else
            valid <= valid_nxt;
    end

    assign stage_valid   = valid;
    assign stage_allowin = allowin;
    assign stage_load    = allowin & {done[NSTAGE-2:0], 1'b1};

    nx_sat_cnt #(.W(CNT_W)) u_retire (
        .clk (clk),
        .rst (rst),
        .inc (done[NSTAGE-1]),
        .clr (cnt_clr),
        .cnt (retire_cnt)
    );

    nx_sat_cnt #(.W(CNT_W)) u_stall (
        .clk (clk),
        .rst (rst),
        .inc (fetch_valid & ~allowin[IF] & ~flush_req),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

endmodule

// File: doc/nx_pipe_ctrl.md
NX_PIPE_CTRL -- requirements
Module: nx_pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, number of pipeline stages (index 0 = IF, NSTAGE-1 = WB); legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 32, width of the statistics counters.
REQ-003 SHALL have parameter SIDX_W, default 3, width of the stage index; SIDX_W >= clog2(NSTAGE).
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports in order below.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 fetch_valid  input  1  IF presents a new instruction this cycle.
REQ-008 ready_go  input  NSTAGE  bit i: stage i finishes its work this cycle (0 = multi-cycle op or hazard stall).
REQ-009 flush_req  input  1  redirect (branch/jump) issued by stage flush_stage.
REQ-010 flush_stage  input  SIDX_W  index of the redirecting stage.
REQ-011 cnt_clr  input  1  synchronous clear of both counters.
REQ-012 stage_valid  output  NSTAGE  bit i: stage i holds a live instruction.
REQ-013 stage_allowin  output  NSTAGE  bit i: stage i accepts new contents this cycle.
REQ-014 stage_load  output  NSTAGE  bit i: load enable for stage i's pipeline register.
REQ-015 retire_cnt  output  CNT_W  instructions retired from stage NSTAGE-1.
REQ-016 stall_cnt  output  CNT_W  cycles with fetch_valid=1 and stage_allowin[0]=0.

Function
REQ-017 allowin[NSTAGE-1] SHALL be !valid[NSTAGE-1] | ready_go[NSTAGE-1]; the last stage always drains.
REQ-018 allowin[i], i<NSTAGE-1, SHALL be !valid[i] | (ready_go[i] & allowin[i+1]); purely combinational, same cycle.
REQ-019 stage_load[0] SHALL equal allowin[0]; stage_load[i], i>0, SHALL equal allowin[i] & valid[i-1] & ready_go[i-1].
REQ-020 On each edge with allowin[0]=1, valid[0] SHALL take fetch_valid; otherwise it holds.
REQ-021 On each edge with allowin[i]=1, i>0, valid[i] SHALL take valid[i-1] & ready_go[i-1] (bubble inserted when the previous stage is not done).
REQ-022 Flush with flush_stage=k SHALL clear valid[0..k] at the next edge, except valid[k] holds 1 when ready_go[k]=0 (redirecting instruction kept); stages > k behave per REQ-020/021; fetch_valid on the flush cycle is discarded.
REQ-023 flush_stage=0 SHALL discard only the incoming fetch; flush_stage >= NSTAGE SHALL be ignored.
REQ-024 retire_cnt SHALL increment by 1 on each edge with valid[NSTAGE-1] & ready_go[NSTAGE-1], independent of flush.
REQ-025 stall_cnt SHALL increment by 1 on each edge with fetch_valid & !allowin[0] & !flush_req.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1; cnt_clr SHALL force 0 and win over a simultaneous increment.
REQ-027 Latency: instruction fetched at edge n, all stages ready, SHALL retire at edge n+NSTAGE.

Reset
REQ-028 rst=1 SHALL immediately force stage_valid=0, retire_cnt=0, stall_cnt=0, independent of clk.
REQ-029 During and after reset, stage_allowin SHALL be all-ones and stage_load SHALL be 1 only at bit 0 (combinational on the cleared valids).
REQ-030 Reset asserted mid-operation SHALL drop every in-flight instruction; no retire counted at the reset edge.

Structure
REQ-031 Shared package nx_pipe_pkg SHALL hold default NSTAGE, CNT_W, SIDX_W and stage-index constants IF=0, ID=1, EXE=2, MEM=3, WB=4.
REQ-032 One sub-module nx_sat_cnt (CNT_W-wide saturating counter with inc and clr) SHALL be instantiated twice.

Verification (NSTAGE=5, CNT_W=32 unless noted)
REQ-033 Reset, fetch_valid=1, ready_go=5'b11111 for 10 edges -> stage_valid 00001,00011,...,11111 after edge 5; retire_cnt=5 after edge 10; stall_cnt=0.
REQ-034 Full pipe, ready_go[2]=0 for 3 cycles -> allowin=5'b11000; valid[3] becomes 0 (bubble); stall_cnt=3; stages 0-2 hold contents.
REQ-035 Full pipe, flush_req=1, flush_stage=2, ready_go all 1 -> next stage_valid=5'b11000; with ready_go[2]=0 instead -> 5'b10100.
REQ-036 CNT_W=4, 20 retires -> retire_cnt=15; cnt_clr with a simultaneous retire -> 0.
REQ-037 rst pulsed asynchronously between edges with full pipe -> stage_valid=0 and counters=0 before the next edge; refill per REQ-033.
